// File: rtl/exec_alu_branch_unit.sv
// exec_alu_branch_unit
// ---------------------------------------------------------------------------
// Execute-stage datapath slice for the single-cycle ARM core. Contains a
// WIDTH-bit ALU with N/Z/V/C flags, a clocked status-flag register, a PC+4
// adder and a branch-target adder fed by the scaled branch offset. All
// arithmetic is combinational; only the flag register holds state.
//
// Optional build macro: ALU_LOGIC_OPS_EN
//   defined   -> alu_op 100/101/110 perform AND/OR/XOR
//   undefined -> those codes return zero and no logic-op hardware is built
//
// Ports:
//   clk        in   clock, flag register updates on the rising edge
//   rst        in   asynchronous active-high reset (clears flags_q only)
//   a          in   ALU operand A (Rn)
//   b          in   ALU operand B (Rm or extended immediate)
//   alu_op     in   operation select (000 pass B, 010 add, 011 sub,
//                   100 and, 101 or, 110 xor, 001/111 zero)
//   flag_we    in   load {n,z,v,c} into flags_q at the next rising edge
//   pc         in   current program counter
//   br_offset  in   sign-extended branch offset in instructions
//   result     out  ALU result
//   n, z, v, c out  flags of the current operation
//   flags_q    out  registered flags {n,z,v,c}
//   pc_plus4   out  pc + 4
//   br_target  out  pc + (br_offset << BR_SHIFT)
// ---------------------------------------------------------------------------
module exec_alu_branch_unit #(
  parameter int WIDTH    = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_offset,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c,
  output logic [3:0]       flags_q,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target
);

  localparam logic [2:0] OpPassB = 3'b000;
  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpSub   = 3'b011;
`ifdef ALU_LOGIC_OPS_EN
  localparam logic [2:0] OpAnd   = 3'b100;
  localparam logic [2:0] OpOr    = 3'b101;
  localparam logic [2:0] OpXor   = 3'b110;
`endif

  logic             isSub;
  logic             isArith;
  logic [WIDTH-1:0] adderB;
  logic [WIDTH:0]   adderSum;
  logic [WIDTH-1:0] brShifted;
  logic [3:0]       flagReg_d;
  logic [3:0]       flagReg_q;

  // One shared adder serves add and subtract: subtract is a + ~b + 1, so
  // the carry out directly means "no borrow" and the overflow test can
  // look at the actual adder inputs in both cases.
  assign isSub    = (alu_op == OpSub);
  assign isArith  = (alu_op == OpAdd) || isSub;
  assign adderB   = isSub ? ~b : b;
  assign adderSum = {1'b0, a} + {1'b0, adderB} + {{WIDTH{1'b0}}, isSub};

  always_comb begin
    result = '0;
    unique case (alu_op)
      OpPassB: result = b;
      OpAdd,
      OpSub:   result = adderSum[WIDTH-1:0];
`ifdef ALU_LOGIC_OPS_EN
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
`endif
      default: result = '0;
    endcase
  end

  // Overflow: adder inputs agree in sign but the sum's sign differs.
  assign n = result[WIDTH-1];
  assign z = (result == '0);
  assign c = isArith & adderSum[WIDTH];
  assign v = isArith & (a[WIDTH-1] == adderB[WIDTH-1]) &
             (adderSum[WIDTH-1] != a[WIDTH-1]);

  // Offset is in instructions; shifting converts to bytes and drops the
  // top bits, which is harmless because the offset is sign-extended.
  assign brShifted = br_offset << BR_SHIFT;
  assign br_target = pc + brShifted;
  assign pc_plus4  = pc + WIDTH'(4);

  assign flagReg_d = flag_we ? {n, z, v, c} : flagReg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagReg_q <= 4'b0000;
    end else begin
      flagReg_q <= flagReg_d;
    end
  end

  assign flags_q = flagReg_q;

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// tb_exec_alu_branch_unit
// ---------------------------------------------------------------------------
// Directed-vector bench for exec_alu_branch_unit with hand-computed
// expectations. Inputs change on the falling clock edge and outputs are
// sampled 1 time unit later, well away from the rising edge that loads the
// flag register. Logic-op expectations follow ALU_LOGIC_OPS_EN.
// ---------------------------------------------------------------------------
module tb_exec_alu_branch_unit;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             flag_we;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             z;
  logic             v;
  logic             c;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_target;

  int checkCount;
  int passCount;
  int failCount;

  exec_alu_branch_unit #(.WIDTH(WIDTH), .BR_SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .flag_we   (flag_we),
    .pc        (pc),
    .br_offset (br_offset),
    .result    (result),
    .n         (n),
    .z         (z),
    .v         (v),
    .c         (c),
    .flags_q   (flags_q),
    .pc_plus4  (pc_plus4),
    .br_target (br_target)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: every check is counted here.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives ALU inputs on the falling edge and lets the logic settle.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] opA,
                               input logic [WIDTH-1:0] opB, input logic we);
    @(negedge clk);
    alu_op  = op;
    a       = opA;
    b       = opB;
    flag_we = we;
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst        = 1'b1;
    a          = '0;
    b          = '0;
    alu_op     = 3'b000;
    flag_we    = 1'b0;
    pc         = '0;
    br_offset  = '0;

    #2;
    checkOutput("reset_flags", WIDTH'(flags_q), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Add
    applyStimulus(3'b010, 64'd5, 64'd3, 1'b0);
    checkOutput("add_res", result, 64'd8);
    checkOutput("add_nzvc", WIDTH'({n, z, v, c}), 64'h0);
    applyStimulus(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    checkOutput("add_wrap_res", result, 64'h0);
    checkOutput("add_wrap_nzvc", WIDTH'({n, z, v, c}), 64'h5);

    // Subtract
    applyStimulus(3'b011, 64'd3, 64'd5, 1'b0);
    checkOutput("sub_neg_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("sub_neg_nzvc", WIDTH'({n, z, v, c}), 64'h8);
    applyStimulus(3'b011, 64'd5, 64'd5, 1'b0);
    checkOutput("sub_zero_res", result, 64'h0);
    checkOutput("sub_zero_nzvc", WIDTH'({n, z, v, c}), 64'h5);

    // Signed overflow
    applyStimulus(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    checkOutput("add_ovf_res", result, 64'h8000_0000_0000_0000);
    checkOutput("add_ovf_nzvc", WIDTH'({n, z, v, c}), 64'hA);
    applyStimulus(3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    checkOutput("sub_ovf_res", result, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("sub_ovf_nzvc", WIDTH'({n, z, v, c}), 64'h3);

    // Pass-B and logic ops
    applyStimulus(3'b000, 64'hF0, 64'h3C, 1'b0);
    checkOutput("passb_res", result, 64'h3C);
    checkOutput("passb_nzvc", WIDTH'({n, z, v, c}), 64'h0);
    applyStimulus(3'b000, 64'h1, 64'h8000_0000_0000_0000, 1'b0);
    checkOutput("passb_neg_nzvc", WIDTH'({n, z, v, c}), 64'h8);
`ifdef ALU_LOGIC_OPS_EN
    applyStimulus(3'b100, 64'hF0, 64'h3C, 1'b0);
    checkOutput("and_res", result, 64'h30);
    applyStimulus(3'b101, 64'hF0, 64'h3C, 1'b0);
    checkOutput("or_res", result, 64'hFC);
    applyStimulus(3'b110, 64'hF0, 64'h3C, 1'b0);
    checkOutput("xor_res", result, 64'hCC);
    checkOutput("xor_nzvc", WIDTH'({n, z, v, c}), 64'h0);
`else
    applyStimulus(3'b100, 64'hF0, 64'h3C, 1'b0);
    checkOutput("and_off_res", result, 64'h0);
    checkOutput("and_off_nzvc", WIDTH'({n, z, v, c}), 64'h4);
    applyStimulus(3'b110, 64'hF0, 64'h3C, 1'b0);
    checkOutput("xor_off_res", result, 64'h0);
`endif
    applyStimulus(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checkOutput("op111_res", result, 64'h0);
    checkOutput("op111_nzvc", WIDTH'({n, z, v, c}), 64'h4);
    applyStimulus(3'b001, 64'd7, 64'd9, 1'b0);
    checkOutput("op001_res", result, 64'h0);

    // Branch / PC paths
    @(negedge clk);
    pc        = 64'h100;
    br_offset = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    checkOutput("br_back", br_target, 64'hF8);
    checkOutput("pc4", pc_plus4, 64'h104);
    br_offset = 64'd3;
    #1;
    checkOutput("br_fwd", br_target, 64'h10C);
    br_offset = 64'h4000_0000_0000_0001;
    #1;
    checkOutput("br_topdrop", br_target, 64'h104);
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    checkOutput("pc4_wrap", pc_plus4, 64'h0);

    // Flag register
    applyStimulus(3'b011, 64'd5, 64'd5, 1'b1);
    checkOutput("flags_before_edge", WIDTH'(flags_q), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("flags_load_sub", WIDTH'(flags_q), 64'h5);
    applyStimulus(3'b010, 64'd5, 64'd3, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("flags_hold", WIDTH'(flags_q), 64'h5);
    applyStimulus(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("flags_load_ovf", WIDTH'(flags_q), 64'hA);

    // Reset between edges clears flags at once; datapath unaffected.
    @(negedge clk);
    flag_we = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("flags_async_rst", WIDTH'(flags_q), 64'h0);
    checkOutput("res_during_rst", result, 64'h8000_0000_0000_0000);
    @(posedge clk);
    #1;
    checkOutput("flags_rst_held", WIDTH'(flags_q), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("flags_no_we_after_rst", WIDTH'(flags_q), 64'h0);
    applyStimulus(3'b011, 64'd3, 64'd5, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("flags_first_load", WIDTH'(flags_q), 64'h8);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/exec_alu_branch_unit.md
Name: exec_alu_branch_unit

Overview:
- Execute-stage datapath slice for the single-cycle ARM core.
- Provides:
  - a 64-bit ALU with N/Z/V/C flags;
  - a registered status-flag register;
  - a PC+4 adder;
  - a branch-target adder fed by a left-shift-by-2 of the sign-extended offset.
- Sits between the register file/immediate muxes and the PC/writeback muxes.
- All arithmetic is combinational; only the flag register is clocked.

Parameters:
- WIDTH, 64, datapath width in bits for operands, PC and offsets.
- BR_SHIFT, 2, left-shift applied to the branch offset (word-to-byte scaling).

Ports:
- clk  input  1  clock; flag register updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  WIDTH  ALU operand A (Rn data).
- b  input  WIDTH  ALU operand B (Rm data or extended immediate).
- alu_op  input  3  ALU operation select.
- flag_we  input  1  when 1, the current flags are loaded into flags_q at the next rising edge.
- pc  input  WIDTH  current program counter.
- br_offset  input  WIDTH  sign-extended branch offset, in instructions.
- result  output  WIDTH  ALU result (combinational).
- n, z, v, c  output  1 each  current flags from this cycle's operation (combinational).
- flags_q  output  4  registered flags {n,z,v,c}.
- pc_plus4  output  WIDTH  pc + 4 (combinational).
- br_target  output  WIDTH  pc + (br_offset << BR_SHIFT) (combinational).

Behaviour:
- alu_op encoding:
  - 000: result = b.
  - 010: result = a + b.
  - 011: result = a - b, computed as a + ~b + 1.
  - 100: result = a & b.
  - 101: result = a | b.
  - 110: result = a ^ b.
  - 001, 111: result = 0.
- Flags:
  - n = result[WIDTH-1].
  - z = (result == 0).
  - For 010 and 011:
    - c = carry out of bit WIDTH-1 of the adder. For subtract, c = 1 means no borrow (a >= b unsigned).
    - v = 1 when both adder inputs have equal sign bits and the result sign differs. For subtract the adder inputs are a and ~b.
  - For all other ops: c = 0 and v = 0.
- All arithmetic wraps modulo 2^WIDTH; there is no saturation.
- Shift-by-2 path:
  - shifted = {br_offset[WIDTH-3:0], 2'b00}; the top two bits are discarded, zeros are shifted in.
  - br_target = pc + shifted, wrapping.
  - Negative offsets produce backward targets.
- pc_plus4 = pc + 4, wrapping: pc = 0xFFFF_FFFF_FFFF_FFFC gives 0.
- Latency:
  - result, n/z/v/c, pc_plus4 and br_target are combinational (0 cycles).
  - flags_q is valid 1 cycle after flag_we is sampled.
- Flag register:
  - rst = 1: flags_q = 4'b0000 immediately, regardless of clk.
  - On a rising clk edge with rst = 0 and flag_we = 1: flags_q <= {n,z,v,c}.
  - With flag_we = 0: flags_q holds.
  - Reset asserted mid-operation clears flags_q at once. The combinational outputs are unaffected by rst.
  - On deassertion of rst, the first load occurs at the next rising edge with flag_we = 1.
- All combinational outputs are fully defined for every input combination; no X propagation from unused ops.

Optional Feature:
- Macro: ALU_LOGIC_OPS_EN.
- Defined: op codes 100/101/110 perform AND/OR/XOR as above.
- Undefined:
  - Op codes 100/101/110 behave like 001/111: result = 0, so z = 1 and n = v = c = 0.
  - The logic-op hardware is not built.
- Add, subtract, pass-B and all PC/branch paths are identical in both builds.

Test Plan:
- Add: alu_op = 010, a = 5, b = 3 -> result = 8, n/z/v/c = 0/0/0/0. Then a = 0xFFFF_FFFF_FFFF_FFFF, b = 1 -> result = 0, z = 1, c = 1, v = 0.
- Subtract: alu_op = 011, a = 3, b = 5 -> result = 0xFFFF_FFFF_FFFF_FFFE, n = 1, z = 0, c = 0, v = 0. Then a = 5, b = 5 -> result = 0, z = 1, c = 1.
- Signed overflow:
  - 010 with a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 -> result = 0x8000_0000_0000_0000, n = 1, v = 1, c = 0.
  - 011 with a = 0x8000_0000_0000_0000, b = 1 -> result = 0x7FFF_FFFF_FFFF_FFFF, v = 1, c = 1.
- Logic and pass (ALU_LOGIC_OPS_EN defined): a = 0xF0, b = 0x3C.
  - 100 -> 0x30.
  - 101 -> 0xFC.
  - 110 -> 0xCC.
  - 000 -> 0x3C, with c = v = 0.
  - Without the macro, 100 -> 0 and z = 1.
- Branch/PC:
  - pc = 0x100, br_offset = 0xFFFF_FFFF_FFFF_FFFE (-2) -> br_target = 0xF8, pc_plus4 = 0x104.
  - br_offset = 3 -> br_target = 0x10C.
  - pc = 0xFFFF_FFFF_FFFF_FFFC -> pc_plus4 = 0.
- Flag register:
  - After subtract 5 - 5 with flag_we = 1 and one clk edge -> flags_q = 4'b0101.
  - Drive add 5 + 3 with flag_we = 0 for one edge -> flags_q stays 0101.
  - Assert rst between edges -> flags_q = 0000 immediately.
